// File: rtl/blink_mode_ctrl_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings and default timing constants.
package blink_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BINARY = 2'd3
  } mode_e;

  localparam int unsigned TICK_TH_DEFAULT = 25000000;
  localparam int unsigned DEB_TH_DEFAULT  = 1000000;
  localparam int unsigned CW_DEFAULT      = 32;

  // OFF -> BLINK -> CHASE -> BINARY -> OFF
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce
  import blink_mode_ctrl_pkg::*;
#(
  parameter int unsigned P_DEB_TH = DEB_TH_DEFAULT,
  parameter int unsigned P_CW     = CW_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam logic [P_CW-1:0] DebLast = P_CW'((P_DEB_TH > 1) ? P_DEB_TH - 1 : 0);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            pulse_q, pulse_d;
  logic [P_CW-1:0] cnt_q, cnt_d;

  // Until the first level is confirmed after reset the counter runs unconditionally and that
  // first commit never pulses, so a button held through reset release is not seen as a press.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    if (armed_q && (sync2_q == level_q)) begin
      cnt_d = '0;
    end else if (cnt_q >= DebLast) begin
      level_d = sync2_q;
      cnt_d   = '0;
      armed_d = 1'b1;
      pulse_d = armed_q & sync2_q & ~level_q;
    end else begin
      cnt_d = cnt_q + P_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_pulse = pulse_q;

endmodule

// File: rtl/blink_mode_ctrl.sv
// Shared LED pattern engine: debounced button cycles the display mode, switches gate and
// select the step rate of a common tick.
module blink_mode_ctrl
  import blink_mode_ctrl_pkg::*;
#(
  parameter int unsigned P_TICK_TH = TICK_TH_DEFAULT,
  parameter int unsigned P_DEB_TH  = DEB_TH_DEFAULT,
  parameter int unsigned P_CW      = CW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_btn,
  input  logic [1:0] sw,
  output logic [3:0] o_led,
  output logic [1:0] o_mode
);

  localparam logic [P_CW-1:0] ThFull = P_CW'((P_TICK_TH > 0) ? P_TICK_TH : 1);
  localparam logic [P_CW-1:0] ThHalf = P_CW'(((P_TICK_TH >> 1) > 0) ? (P_TICK_TH >> 1) : 1);

  logic btn_pulse;
  logic unused_btn_level;

  btn_debounce #(
    .P_DEB_TH (P_DEB_TH),
    .P_CW     (P_CW)
  ) u_btn_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (i_btn),
    .o_level (unused_btn_level),
    .o_pulse (btn_pulse)
  );

  logic [P_CW-1:0] th_sel;
  logic [P_CW-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick;

  // >= rather than == so a switch to the fast rate past the new threshold still ticks at once.
  always_comb begin
    th_sel     = sw[1] ? ThHalf : ThFull;
    tick       = sw[0] && (tick_cnt_q >= (th_sel - P_CW'(1)));
    tick_cnt_d = tick_cnt_q;
    if (sw[0]) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + P_CW'(1);
    end
  end

  mode_e      mode_q, mode_d;
  logic       phase_q, phase_d;
  logic [3:0] onehot_q, onehot_d;
  logic [3:0] bin_q, bin_d;
  logic [3:0] led_q, led_d;

  // A mode change takes priority over a coincident tick and restarts every pattern.
  always_comb begin
    mode_d   = mode_q;
    phase_d  = phase_q;
    onehot_d = onehot_q;
    bin_d    = bin_q;
    led_d    = 4'b0000;
    if (btn_pulse) begin
      mode_d   = next_mode(mode_q);
      phase_d  = 1'b0;
      onehot_d = 4'b0001;
      bin_d    = 4'd0;
    end else if (tick) begin
      phase_d  = ~phase_q;
      onehot_d = {onehot_q[2:0], onehot_q[3]};
      bin_d    = bin_q + 4'd1;
    end
    unique case (mode_d)
      MODE_OFF:    led_d = 4'b0000;
      MODE_BLINK:  led_d = {4{phase_d}};
      MODE_CHASE:  led_d = onehot_d;
      MODE_BINARY: led_d = bin_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      mode_q     <= MODE_OFF;
      phase_q    <= 1'b0;
      onehot_q   <= 4'b0001;
      bin_q      <= 4'd0;
      led_q      <= 4'b0000;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      onehot_q   <= onehot_d;
      bin_q      <= bin_d;
      led_q      <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Self-checking bench for blink_mode_ctrl: reset, debounce, per-mode sequences and rates,
// button/tick collision and on-the-fly rate switch.
module tb_blink_mode_ctrl;

  localparam int TickTh = 8;
  localparam int DebTh  = 4;
  // raw button -> 2 sync flops -> DebTh-cycle count -> registered pulse -> mode register
  localparam int PressLat = DebTh + 3;

  typedef struct {
    logic [1:0] sw;
    logic [3:0] led;
    logic [1:0] mode;
    int         gap;   // cycles since previous LED change; 0 = not checked
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       i_btn;
  logic [1:0] sw;
  logic [3:0] o_led;
  logic [1:0] o_mode;

  int n_chk = 0;
  int n_err = 0;

  vec_t chase_tbl[4];
  vec_t bin_tbl[16];
  vec_t exp_q[$];

  blink_mode_ctrl #(
    .P_TICK_TH (TickTh),
    .P_DEB_TH  (DebTh),
    .P_CW      (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_btn   (i_btn),
    .sw      (sw),
    .o_led   (o_led),
    .o_mode  (o_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int settle);
    i_btn = 1'b1;
    cycles(hold);
    i_btn = 1'b0;
    cycles(settle);
  endtask

  task automatic wait_change(input int max, output int gap, output bit seen);
    logic [3:0] prev;
    prev = o_led;
    gap  = 0;
    seen = 1'b0;
    while (!seen && gap < max) begin
      @(negedge clk);
      gap++;
      if (o_led !== prev) seen = 1'b1;
    end
  endtask

  task automatic sb_step(input string name, input int max);
    vec_t e;
    int   gap;
    bit   seen;
    e  = exp_q.pop_front();
    sw = e.sw;
    wait_change(max, gap, seen);
    chk($sformatf("%s_seen", name), 32'(seen), 32'd1);
    if (seen) begin
      chk($sformatf("%s_led", name), 32'(o_led), 32'(e.led));
      chk($sformatf("%s_mode", name), 32'(o_mode), 32'(e.mode));
      if (e.gap != 0) chk($sformatf("%s_gap", name), 32'(gap), 32'(e.gap));
    end
  endtask

  initial begin
    int         gap;
    bit         seen;
    logic [3:0] v;

    chase_tbl[0] = '{2'b01, 4'b0010, 2'd2, 0};
    chase_tbl[1] = '{2'b01, 4'b0100, 2'd2, TickTh};
    chase_tbl[2] = '{2'b01, 4'b1000, 2'd2, TickTh};
    chase_tbl[3] = '{2'b01, 4'b0001, 2'd2, TickTh};
    for (int i = 0; i < 16; i++) begin
      bin_tbl[i] = '{2'b11, 4'(i + 1), 2'd3, (i == 0) ? 0 : TickTh / 2};
    end

    // Reset with button held and switches on; release must not register a press.
    reset_n = 1'b0;
    i_btn   = 1'b1;
    sw      = 2'b11;
    cycles(5);
    chk("reset_led", 32'(o_led), 32'd0);
    chk("reset_mode", 32'(o_mode), 32'd0);
    reset_n = 1'b1;
    cycles(20);
    chk("release_held_mode", 32'(o_mode), 32'd0);
    i_btn = 1'b0;
    cycles(12);
    chk("release_let_go_mode", 32'(o_mode), 32'd0);

    // Debounce: short bounce ignored, long press advances exactly once.
    press(3, 12);
    chk("short_bounce_mode", 32'(o_mode), 32'd0);
    sw    = 2'b00;
    i_btn = 1'b1;
    cycles(PressLat - 1);
    chk("press_lat_before", 32'(o_mode), 32'd0);
    cycles(1);
    chk("press_lat_mode", 32'(o_mode), 32'd1);
    chk("blink_entry_led", 32'(o_led), 32'd0);
    cycles(10 - PressLat);
    i_btn = 1'b0;
    cycles(12);
    chk("one_advance_mode", 32'(o_mode), 32'd1);

    // BLINK at full rate, half rate, then frozen.
    sw = 2'b01;
    wait_change(TickTh + 2, gap, seen);
    chk("blink_align_seen", 32'(seen), 32'd1);
    v = o_led;
    chk("blink_level", 32'((v == 4'h0) || (v == 4'hf)), 32'd1);
    exp_q.push_back('{2'b01, ~v, 2'd1, TickTh});
    exp_q.push_back('{2'b01, v, 2'd1, TickTh});
    exp_q.push_back('{2'b01, ~v, 2'd1, TickTh});
    for (int i = 0; i < 3; i++) sb_step("blink_slow", TickTh + 4);
    sw = 2'b11;
    wait_change(TickTh + 2, gap, seen);
    chk("blink_fast_align_seen", 32'(seen), 32'd1);
    v = o_led;
    exp_q.push_back('{2'b11, ~v, 2'd1, TickTh / 2});
    exp_q.push_back('{2'b11, v, 2'd1, TickTh / 2});
    exp_q.push_back('{2'b11, ~v, 2'd1, TickTh / 2});
    for (int i = 0; i < 3; i++) sb_step("blink_fast", TickTh);
    sw = 2'b00;
    wait_change(50, gap, seen);
    chk("blink_frozen_change", 32'(seen), 32'd0);
    chk("blink_frozen_mode", 32'(o_mode), 32'd1);

    // CHASE: entry value then full rotation with wrap.
    press(10, 12);
    chk("chase_entry_mode", 32'(o_mode), 32'd2);
    chk("chase_entry_led", 32'(o_led), 32'b0001);
    foreach (chase_tbl[i]) exp_q.push_back(chase_tbl[i]);
    for (int i = 0; i < 4; i++) sb_step("chase", TickTh + 4);

    // BINARY: count 1..15 then wrap to 0 at half rate; next press returns to OFF.
    sw = 2'b00;
    press(10, 12);
    chk("binary_entry_mode", 32'(o_mode), 32'd3);
    chk("binary_entry_led", 32'(o_led), 32'd0);
    foreach (bin_tbl[i]) exp_q.push_back(bin_tbl[i]);
    for (int i = 0; i < 16; i++) sb_step("binary", TickTh);
    press(10, 12);
    chk("off_mode", 32'(o_mode), 32'd0);
    chk("off_led", 32'(o_led), 32'd0);
    wait_change(20, gap, seen);
    chk("off_dark_change", 32'(seen), 32'd0);

    // Collision: time the button so the mode change lands on a tick edge in CHASE.
    sw = 2'b01;
    press(10, 12);
    press(10, 12);
    chk("coll_setup_mode", 32'(o_mode), 32'd2);
    wait_change(TickTh + 2, gap, seen);
    chk("coll_align_seen", 32'(seen), 32'd1);
    @(negedge clk);
    i_btn = 1'b1;
    cycles(PressLat - 1);
    chk("coll_before_mode", 32'(o_mode), 32'd2);
    cycles(1);
    i_btn = 1'b0;
    chk("coll_mode", 32'(o_mode), 32'd3);
    chk("coll_led", 32'(o_led), 32'd0);
    exp_q.push_back('{2'b01, 4'b0001, 2'd3, TickTh});
    sb_step("coll_next", TickTh + 4);

    // Rate switch with the counter at 6: tick on the very next edge, then half period.
    cycles(6);
    exp_q.push_back('{2'b11, 4'b0010, 2'd3, 1});
    exp_q.push_back('{2'b11, 4'b0011, 2'd3, TickTh / 2});
    exp_q.push_back('{2'b11, 4'b0100, 2'd3, TickTh / 2});
    for (int i = 0; i < 3; i++) sb_step("rate_switch", TickTh);

    // Asynchronous reset mid-operation.
    cycles(1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(o_led), 32'd0);
    chk("async_reset_mode", 32'(o_mode), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(3);
    chk("after_reset_mode", 32'(o_mode), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
